// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with prioritised redirect channels and a one-entry park buffer.
// Latency: an incoming redirect reaches pc after one edge; a parked one after the first pc_write edge.
// Backpressure: pc_write=0 holds pc; the best redirect seen while stalled is parked until fetch advances.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   pc_write          fetch advance enable (0 = stall)
//   redir_valid       per-channel redirect request, index 0 = highest priority
//   redir_target      channel i target at [i*XLEN +: XLEN]
//   pc                current fetch PC
//   pc_redirected     one-cycle pulse: pc was loaded from a redirect at the last edge
//   redir_pending     a parked redirect is waiting for pc_write
//   pending_src       channel index of the parked redirect
module pc_redirect_unit #(
    parameter int          XLEN       = 64,
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int          NUM_REDIR  = 3,
    parameter int          INST_BYTES = 4,
    localparam int         SW         = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pc_write,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target,
    output logic [XLEN-1:0]           pc,
    output logic                      pc_redirected,
    output logic                      redir_pending,
    output logic [SW-1:0]             pending_src
);

    logic [XLEN-1:0] pending_target;

    // Winner among this cycle's requests: lowest asserted index.
    logic            win;
    logic [SW-1:0]   win_idx;
    logic [XLEN-1:0] win_tgt;

    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        win_tgt = '0;
        // Walk from the lowest priority upward so the last hit is the winner.
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                win     = 1'b1;
                win_idx = SW'(i);
                win_tgt = redir_target[i*XLEN +: XLEN];
            end
        end
    end

    // Effective redirect: an incoming winner beats (or replaces, on equal
    // index) the parked entry; a younger-path incoming request is dropped.
    logic            take_new;
    logic            eff_vld;
    logic [SW-1:0]   eff_src;
    logic [XLEN-1:0] eff_tgt;

    always_comb begin
        take_new = win && (!redir_pending || (win_idx <= pending_src));
        eff_vld  = take_new || redir_pending;
        eff_src  = take_new ? win_idx : pending_src;
        eff_tgt  = take_new ? win_tgt : pending_target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC[XLEN-1:0];
            pc_redirected  <= 1'b0;
            redir_pending  <= 1'b0;
            pending_src    <= '0;
            pending_target <= '0;
        end else if (pc_write) begin
            // Sequential increment wraps modulo 2^XLEN; targets are used verbatim.
            pc            <= eff_vld ? eff_tgt : pc + XLEN'(INST_BYTES);
            pc_redirected <= eff_vld;
            redir_pending <= 1'b0;
        end else begin
            pc_redirected <= 1'b0;
            if (eff_vld) begin
                redir_pending  <= 1'b1;
                pending_src    <= eff_src;
                pending_target <= eff_tgt;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

    localparam int          XLEN   = 64;
    localparam int          NR     = 3;
    localparam int          SW     = 2;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 pc_write;
    logic [NR-1:0]        redir_valid;
    logic [NR*XLEN-1:0]   redir_target;
    logic [XLEN-1:0]      pc;
    logic                 pc_redirected;
    logic                 redir_pending;
    logic [SW-1:0]        pending_src;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference state, advanced once per clock edge from the behavioural rules.
    logic [63:0] m_pc;
    logic        m_red;
    logic        m_pend;
    int          m_src;
    logic [63:0] m_tgt;

    pc_redirect_unit #(
        .XLEN(XLEN), .RESET_PC(RST_PC), .NUM_REDIR(NR), .INST_BYTES(4)
    ) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .pc(pc), .pc_redirected(pc_redirected),
        .redir_pending(redir_pending), .pending_src(pending_src)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = RST_PC; m_red = 0; m_pend = 0; m_src = 0; m_tgt = '0;
    endtask

    task automatic set_tgt(input int ch, input logic [63:0] val);
        redir_target[ch*XLEN +: XLEN] = val;
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        int          w;
        logic        e;
        int          e_src;
        logic [63:0] e_tgt;
        w = -1;
        for (int i = 0; i < NR; i++)
            if (redir_valid[i] && w < 0) w = i;
        e = 0; e_src = 0; e_tgt = '0;
        if (w >= 0 && (!m_pend || w <= m_src)) begin
            e = 1; e_src = w; e_tgt = redir_target[w*XLEN +: XLEN];
        end else if (m_pend) begin
            e = 1; e_src = m_src; e_tgt = m_tgt;
        end
        if (pc_write) begin
            m_pc   = e ? e_tgt : m_pc + 64'd4;
            m_pend = 0;
            m_red  = e;
        end else begin
            m_red = 0;
            if (e) begin
                m_pend = 1; m_src = e_src; m_tgt = e_tgt;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; pc_write = 0; redir_valid = '0; redir_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (pc !== RST_PC || pc_redirected !== 1'b0 || redir_pending !== 1'b0 || pending_src !== 2'd0) begin
            $display("FAIL reset_state: pc=%h red=%b pend=%b src=%0d want pc=%h 0 0 0",
                     pc, pc_redirected, redir_pending, pending_src, RST_PC);
        end else pass_cnt++;
        reset = 0; pc_write = 1;
        tick(); tick();
        // Asynchronous assertion mid-cycle must take effect without an edge.
        #2 reset = 1;
        #1;
        model_reset();
        chk_cnt++;
        if (pc !== RST_PC || redir_pending !== 1'b0) begin
            $display("FAIL async_reset: pc=%h pend=%b want %h 0", pc, redir_pending, RST_PC);
        end else pass_cnt++;
        #1 reset = 0;
        tick();
        chk_cnt++;
        if (pc !== 64'h8000_0004) $display("FAIL reset_inc1: pc=%h want 80000004", pc);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (pc !== 64'h8000_0008) $display("FAIL reset_inc2: pc=%h want 80000008", pc);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        tick(); tick();
        chk_cnt++;
        if (pc !== 64'h8000_0010) $display("FAIL bypass_start: pc=%h want 80000010", pc);
        else pass_cnt++;
        redir_valid = 3'b010; set_tgt(1, 64'h8000_0100);
        tick();
        redir_valid = '0;
        chk_cnt++;
        if (pc !== 64'h8000_0100 || pc_redirected !== 1'b1 || redir_pending !== 1'b0)
            $display("FAIL bypass_apply: pc=%h red=%b pend=%b want 80000100 1 0",
                     pc, pc_redirected, redir_pending);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (pc !== 64'h8000_0104 || pc_redirected !== 1'b0)
            $display("FAIL bypass_pulse: pc=%h red=%b want 80000104 0", pc, pc_redirected);
        else pass_cnt++;
    endtask

    task automatic test_park();
        pc_write = 0; redir_valid = 3'b100; set_tgt(2, 64'h8000_0200);
        tick();
        redir_valid = '0;
        chk_cnt++;
        if (pc !== 64'h8000_0104 || redir_pending !== 1'b1 || pending_src !== 2'd2 || pc_redirected !== 1'b0)
            $display("FAIL park_hold: pc=%h pend=%b src=%0d red=%b want 80000104 1 2 0",
                     pc, redir_pending, pending_src, pc_redirected);
        else pass_cnt++;
        tick(); tick();
        chk_cnt++;
        if (pc !== 64'h8000_0104 || redir_pending !== 1'b1)
            $display("FAIL park_stall: pc=%h pend=%b want 80000104 1", pc, redir_pending);
        else pass_cnt++;
        pc_write = 1;
        tick();
        chk_cnt++;
        if (pc !== 64'h8000_0200 || redir_pending !== 1'b0 || pc_redirected !== 1'b1)
            $display("FAIL park_apply: pc=%h pend=%b red=%b want 80000200 0 1",
                     pc, redir_pending, pc_redirected);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        pc_write = 0; redir_valid = 3'b100; set_tgt(2, 64'h8000_0250);
        tick();
        redir_valid = 3'b001; set_tgt(0, 64'h8000_0300);
        tick();
        chk_cnt++;
        if (redir_pending !== 1'b1 || pending_src !== 2'd0)
            $display("FAIL prio_override: pend=%b src=%0d want 1 0", redir_pending, pending_src);
        else pass_cnt++;
        redir_valid = 3'b100; set_tgt(2, 64'h8000_0999);
        tick();
        chk_cnt++;
        if (pending_src !== 2'd0) $display("FAIL prio_drop_stall: src=%0d want 0", pending_src);
        else pass_cnt++;
        pc_write = 1;
        tick();
        redir_valid = '0;
        chk_cnt++;
        if (pc !== 64'h8000_0300 || pc_redirected !== 1'b1 || redir_pending !== 1'b0)
            $display("FAIL prio_apply: pc=%h red=%b pend=%b want 80000300 1 0",
                     pc, pc_redirected, redir_pending);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        redir_valid = 3'b001; set_tgt(0, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        redir_valid = '0;
        chk_cnt++;
        if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_load: pc=%h want fffffffffffffffc", pc);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (pc !== 64'h0 || pc_redirected !== 1'b0)
            $display("FAIL wrap_zero: pc=%h red=%b want 0 0", pc, pc_redirected);
        else pass_cnt++;
    endtask

    task automatic test_reset_pending();
        pc_write = 0; redir_valid = 3'b010; set_tgt(1, 64'h8000_0400);
        tick();
        redir_valid = '0;
        chk_cnt++;
        if (redir_pending !== 1'b1 || pending_src !== 2'd1)
            $display("FAIL rstpend_park: pend=%b src=%0d want 1 1", redir_pending, pending_src);
        else pass_cnt++;
        #2 reset = 1;
        #1;
        model_reset();
        chk_cnt++;
        if (redir_pending !== 1'b0 || pc !== RST_PC)
            $display("FAIL rstpend_clear: pend=%b pc=%h want 0 %h", redir_pending, pc, RST_PC);
        else pass_cnt++;
        #1 reset = 0; pc_write = 1;
        tick();
        chk_cnt++;
        if (pc !== 64'h8000_0004 || pc_redirected !== 1'b0)
            $display("FAIL rstpend_after: pc=%h red=%b want 80000004 0", pc, pc_redirected);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 400; n++) begin
            pc_write = ($urandom_range(0, 9) < 6);
            redir_valid = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(1, 7)) : '0;
            for (int i = 0; i < NR; i++) set_tgt(i, {$urandom, $urandom});
            tick();
            bad = (pc !== m_pc) || (pc_redirected !== m_red) ||
                  (redir_pending !== m_pend) || (pending_src !== SW'(m_src));
            chk_cnt++;
            if (bad)
                $display("FAIL random[%0d]: pc=%h red=%b pend=%b src=%0d want pc=%h red=%b pend=%b src=%0d",
                         n, pc, pc_redirected, redir_pending, pending_src, m_pc, m_red, m_pend, m_src);
            else pass_cnt++;
        end
        redir_valid = '0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_park();
        test_priority();
        test_wrap();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
